reg_ab: RTL and testbench

//   General-purpose 8-bit accumulator/operand register (A or B) for the 8-bit CPU datapath.
//   - Loads a byte from the shared tri-state system bus on a clock edge.
//   - Can drive its contents back onto that bus.
//   - Exposes its contents continuously to the ALU.
//   - One instance serves as register A, a second as register B.
//

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/reg_ab_if.sv | 19 +
 rtl/bus_tristate.sv | 22 ++
 rtl/reg_ab.sv | 42 ++++
 tb/tb_reg_ab.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared datapath width, data type and active-low control levels.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  // Control-unit strobes are active-low throughout the datapath.
  localparam logic CTRL_ASSERT   = 1'b0;
  localparam logic CTRL_DEASSERT = 1'b1;

  function automatic logic ctrl_active(input logic sig_n);
    return (sig_n == CTRL_ASSERT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_ab_if.sv
// ============================================================================
// Module  : reg_ab_if
// Brief   : Control strobes and ALU-side data output of a datapath register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_ab_if #(
  parameter int WIDTH = 8
);
  logic             ai_n;
  logic             ao_n;
  logic [WIDTH-1:0] A;

  modport master (output ai_n, output ao_n, input  A);
  modport slave  (input  ai_n, input  ao_n, output A);
endinterface

`default_nettype wire

// File: rtl/bus_tristate.sv
// ============================================================================
// Module  : bus_tristate
// Brief   : Active-low enabled tri-state driver onto the shared system bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_tristate
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  wire              oe_n,
  input  wire  [WIDTH-1:0] din,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = ctrl_active(oe_n) ? din : {WIDTH{1'bz}};

endmodule

`default_nettype wire

// File: rtl/reg_ab.sv
// ============================================================================
// Module  : reg_ab
// Brief   : 8-bit A/B datapath register: loads from bus, drives bus, feeds ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_ab
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  wire              clk,
  input  wire              clr_n,
  inout  wire  [WIDTH-1:0] bus,
  reg_ab_if.slave          ctrl
);

  logic [WIDTH-1:0] r_data;

  // Clear wins over load; bus contents are captured as-is, including X/Z.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_data <= '0;
    end else if (ctrl_active(ctrl.ai_n)) begin
      r_data <= bus;
    end
  end

  assign ctrl.A = r_data;

  bus_tristate #(
    .WIDTH (WIDTH)
  ) u_bus_drv (
    .oe_n (ctrl.ao_n),
    .din  (r_data),
    .bus  (bus)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_ab.sv
// ============================================================================
// Module  : tb_reg_ab
// Brief   : Directed table-driven and hand-sequenced checks for reg_ab.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_ab;

  logic       clk;
  logic       clr_n;
  logic       tb_oe;
  logic [7:0] tb_val;
  wire  [7:0] bus;

  int n_checks = 0;
  int n_fail   = 0;

  reg_ab_if #(.WIDTH(8)) ctrl_if ();

  assign bus = tb_oe ? tb_val : 8'hzz;

  reg_ab #(.WIDTH(8)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus),
    .ctrl  (ctrl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ai_n;
    logic       ao_n;
    logic       drv;
    logic [7:0] val;
    logic [7:0] exp_a;
    logic [7:0] exp_bus;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // With nobody driving, a 4-state simulator sees z; a 2-state one sees 0.
  task automatic check_released(input string name);
    n_checks++;
    if (!((bus === 8'hzz) || (bus === 8'h00))) begin
      n_fail++;
      $display("FAIL %s: got %h expected zz", name, bus);
    end
  endtask

  initial begin
    //           ai_n  ao_n  drv   val    exp_a  exp_bus
    vecs[0] = '{1'b0, 1'b1, 1'b1, 8'hAA, 8'hAA, 8'hAA};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'hAA, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'hAA, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hAA, 8'hAA};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h3C, 8'hAA, 8'h3C};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h5C, 8'h5C, 8'h5C};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 8'h81, 8'h81, 8'h81};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h81, 8'h81};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h81, 8'h81};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 8'h55, 8'h81, 8'h55};

    clr_n          = 1'b0;
    ctrl_if.ai_n   = 1'b1;
    ctrl_if.ao_n   = 1'b1;
    tb_oe          = 1'b0;
    tb_val         = 8'h00;

    #2;
    check("reset_A", ctrl_if.A, 8'h00);
    check_released("reset_bus_z");
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ctrl_if.ai_n = vecs[i].ai_n;
      ctrl_if.ao_n = vecs[i].ao_n;
      tb_oe        = vecs[i].drv;
      tb_val       = vecs[i].val;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_A", i), ctrl_if.A, vecs[i].exp_a);
      check($sformatf("vec%0d_bus", i), bus, vecs[i].exp_bus);
    end

    // Async clear between edges, preloaded with 5C
    @(negedge clk);
    ctrl_if.ai_n = 1'b0; ctrl_if.ao_n = 1'b1; tb_oe = 1'b1; tb_val = 8'h5C;
    @(posedge clk); #1;
    check("preload_A", ctrl_if.A, 8'h5C);
    ctrl_if.ai_n = 1'b1; tb_oe = 1'b0;
    #1;
    clr_n = 1'b0;
    #1;
    check("async_clr_A", ctrl_if.A, 8'h00);
    check_released("async_clr_bus_z");
    ctrl_if.ao_n = 1'b0;
    #1;
    check("clr_drive_bus", bus, 8'h00);
    ctrl_if.ao_n = 1'b1;

    // Clear held across an edge blocks a pending load
    @(negedge clk);
    ctrl_if.ai_n = 1'b0; tb_oe = 1'b1; tb_val = 8'hFF;
    @(posedge clk); #1;
    check("clr_priority_A", ctrl_if.A, 8'h00);
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk); #1;
    check("post_clr_load_A", ctrl_if.A, 8'hFF);

    // Output enable acts within the cycle, then releases cleanly
    ctrl_if.ai_n = 1'b1; tb_oe = 1'b0;
    #1;
    ctrl_if.ao_n = 1'b0;
    #1;
    check("same_cycle_out_bus", bus, 8'hFF);
    check("same_cycle_out_A", ctrl_if.A, 8'hFF);
    ctrl_if.ao_n = 1'b1;
    #1;
    check_released("release_bus_z");
    tb_oe = 1'b1; tb_val = 8'h3C;
    #1;
    check("tb_drive_after_release", bus, 8'h3C);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
